render_scheduler: RTL and testbench

//  Frame-level scheduler for the Mandelbrot render farm: raster-walks a 2**XW x 2**YW image, dispatches pixels to

---
 rtl/render_scheduler.sv | 266 ++++++++++++++++++++++++++
 tb/tb_render_scheduler.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/render_scheduler.sv
// render_scheduler: frame-level scheduler for the Mandelbrot render farm.
// Walks the image in raster order and hands pixels to free-running renderer lanes.
// It writes each lane result into the framebuffer, then streams the frame out as bytes,
// low byte of each pixel first.
// Optional feature macro: RENDER_SCHED_PERF_EN (render/drain cycle counter on perf_cycles).
module render_scheduler #(
  parameter int         LANES       = 4,
  parameter int         XW          = 8,
  parameter int         YW          = 8,
  parameter logic [7:0] ITER_OFFSET = 8'd16,
  parameter logic [7:0] PIX_HI      = 8'd128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [LANES-1:0]    lane_start,
  output logic [LANES*XW-1:0] lane_x,
  output logic [LANES*YW-1:0] lane_y,
  input  logic [LANES-1:0]    lane_done,
  input  logic [LANES*8-1:0]  lane_iters,
  output logic                fb_we,
  output logic [XW+YW-1:0]    fb_addr,
  output logic [15:0]         fb_wdata,
  output logic                fb_re,
  input  logic [15:0]         fb_rdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0]          out_data,
  output logic                out_last,
  output logic [31:0]         perf_cycles
);

  localparam int AW = XW + YW;
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RENDER  = 3'd1,
    S_DRAIN   = 3'd2,
    S_READOUT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    R_REQ = 2'd0,
    R_LO  = 2'd1,
    R_HI  = 2'd2
  } rphase_t;

  // Pixel low byte: iteration count plus offset, wrapping modulo 256.
  function automatic logic [7:0] pix_lo(input logic [7:0] iters);
    return iters + ITER_OFFSET;
  endfunction

  state_t              state_q, state_d;
  logic [XW-1:0]       x_q;
  logic [YW-1:0]       y_q;
  logic [LANES-1:0]    busy_q;
  logic [LANES-1:0]    pend_q;
  logic [7:0]          res_q [LANES];
  logic [AW-1:0]       tag_q [LANES];
  logic [LANES-1:0]    lane_start_q;
  logic [LANES*XW-1:0] lane_x_q;
  logic [LANES*YW-1:0] lane_y_q;
  logic [AW-1:0]       rd_addr_q;
  rphase_t             rph_q;
  logic                lo_first_q;
  logic [15:0]         pix_q;

  logic                disp_hit, disp_en, wr_hit, wr_en, in_frame, frame_go;
  logic [LW-1:0]       disp_idx, wr_idx;
  logic [LANES-1:0]    acc;
  logic                last_coord, rd_last;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state, lane/write arbitration and all combinational outputs
  always_comb begin
    state_d    = state_q;
    disp_hit   = 1'b0;
    disp_idx   = '0;
    wr_hit     = 1'b0;
    wr_idx     = '0;
    acc        = '0;
    busy       = 1'b0;
    done       = 1'b0;
    fb_we      = 1'b0;
    fb_addr    = '0;
    fb_wdata   = '0;
    fb_re      = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_last   = 1'b0;

    in_frame   = (state_q == S_RENDER) || (state_q == S_DRAIN);
    frame_go   = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;
    last_coord = (&x_q) && (&y_q);
    rd_last    = &rd_addr_q;

    // Descending scan leaves the lowest qualifying index selected.
    for (int i = LANES - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        disp_hit = 1'b1;
        disp_idx = LW'(i);
      end
      if (pend_q[i]) begin
        wr_hit = 1'b1;
        wr_idx = LW'(i);
      end
      acc[i] = in_frame && lane_done[i] && busy_q[i] && !pend_q[i];
    end

    disp_en = (state_q == S_RENDER) && disp_hit;
    wr_en   = in_frame && wr_hit;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RENDER;
      end
      S_RENDER: begin
        busy = 1'b1;
        if (disp_en && last_coord) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if ((busy_q == '0) && (pend_q == '0)) state_d = S_READOUT;
      end
      S_READOUT: begin
        busy    = 1'b1;
        fb_addr = rd_addr_q;
        case (rph_q)
          R_REQ: fb_re = 1'b1;
          R_LO: begin
            out_valid = 1'b1;
            // First LO cycle forwards the RAM output directly; later stall cycles use the capture.
            out_data  = lo_first_q ? fb_rdata[7:0] : pix_q[7:0];
          end
          R_HI: begin
            out_valid = 1'b1;
            out_data  = pix_q[15:8];
            out_last  = rd_last;
            if (out_ready && rd_last) state_d = S_DONE;
          end
          default: ;
        endcase
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_d = S_RENDER;
      end
      default: state_d = S_IDLE;
    endcase

    if (wr_en) begin
      fb_we    = 1'b1;
      fb_addr  = tag_q[wr_idx];
      fb_wdata = {PIX_HI, pix_lo(res_q[wr_idx])};
    end
  end

  // Control: raster walk, lane busy/pending flags, dispatch pulses and readout sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q          <= '0;
      y_q          <= '0;
      busy_q       <= '0;
      pend_q       <= '0;
      lane_start_q <= '0;
      lane_x_q     <= '0;
      lane_y_q     <= '0;
      rd_addr_q    <= '0;
      rph_q        <= R_REQ;
      lo_first_q   <= 1'b0;
    end else begin
      lane_start_q <= '0;
      if (frame_go) begin
        x_q       <= '0;
        y_q       <= '0;
        busy_q    <= '0;
        pend_q    <= '0;
        rd_addr_q <= '0;
        rph_q     <= R_REQ;
      end
      if (disp_en) begin
        busy_q[disp_idx]                    <= 1'b1;
        lane_start_q[disp_idx]              <= 1'b1;
        lane_x_q[int'(disp_idx)*XW +: XW]   <= x_q;
        lane_y_q[int'(disp_idx)*YW +: YW]   <= y_q;
        x_q <= x_q + XW'(1);
        if (&x_q) y_q <= y_q + YW'(1);
      end
      for (int i = 0; i < LANES; i++) begin
        if (acc[i]) pend_q[i] <= 1'b1;
      end
      // The written lane is idle from the next cycle and may be re-dispatched then.
      if (wr_en) begin
        pend_q[wr_idx] <= 1'b0;
        busy_q[wr_idx] <= 1'b0;
      end
      if ((state_q == S_DRAIN) && (state_d == S_READOUT)) begin
        rd_addr_q  <= '0;
        rph_q      <= R_REQ;
        lo_first_q <= 1'b0;
      end
      if (state_q == S_READOUT) begin
        case (rph_q)
          R_REQ: begin
            rph_q      <= R_LO;
            lo_first_q <= 1'b1;
          end
          R_LO: begin
            lo_first_q <= 1'b0;
            if (out_ready) rph_q <= R_HI;
          end
          R_HI: begin
            if (out_ready) begin
              rph_q     <= R_REQ;
              rd_addr_q <= rd_addr_q + AW'(1);
            end
          end
          default: rph_q <= R_REQ;
        endcase
      end
    end
  end

  // Datapath: lane results, pixel tags and captured read data (no reset needed)
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (acc[i]) res_q[i] <= lane_iters[i*8 +: 8];
    end
    if (disp_en) tag_q[disp_idx] <= {y_q, x_q};
    if ((state_q == S_READOUT) && (rph_q == R_LO) && lo_first_q) pix_q <= fb_rdata;
  end

  assign lane_start = lane_start_q;
  assign lane_x     = lane_x_q;
  assign lane_y     = lane_y_q;

`ifdef RENDER_SCHED_PERF_EN
  // Saturating increment for the cycle counter.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] perf_q;

  // Count RENDER/DRAIN cycles; cleared at frame start, frozen outside the render phase
  always_ff @(posedge clk) begin
    if (rst)           perf_q <= '0;
    else if (frame_go) perf_q <= '0;
    else if (in_frame) perf_q <= sat_inc32(perf_q);
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_render_scheduler.sv
// Bench for render_scheduler: small 4x2 image, two lanes modelled with configurable latency,
// framebuffer modelled as a one-cycle-latency memory, byte stream checked through a scoreboard.
module tb_render_scheduler;
  localparam int LANES = 2;
  localparam int XW    = 2;
  localparam int YW    = 1;
  localparam int AW    = XW + YW;
  localparam int NPIX  = 1 << AW;

  logic                clk = 1'b0;
  logic                rst, start, busy, done;
  logic [LANES-1:0]    lane_start, lane_done;
  logic [LANES*XW-1:0] lane_x;
  logic [LANES*YW-1:0] lane_y;
  logic [LANES*8-1:0]  lane_iters;
  logic                fb_we, fb_re, out_valid, out_ready, out_last;
  logic [AW-1:0]       fb_addr;
  logic [15:0]         fb_wdata, fb_rdata;
  logic [7:0]          out_data;
  logic [31:0]         perf_cycles;

  render_scheduler #(.LANES(LANES), .XW(XW), .YW(YW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .lane_start(lane_start), .lane_x(lane_x), .lane_y(lane_y),
    .lane_done(lane_done), .lane_iters(lane_iters),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .fb_re(fb_re), .fb_rdata(fb_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .perf_cycles(perf_cycles)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [7:0]  iters_tab [NPIX];
  logic [15:0] mem [NPIX];
  int          wr_cnt [NPIX];
  logic [8:0]  exp_q [$];
  int          lat [LANES];
  bit          lat_rand = 1'b0;
  int          rdy_mode = 0;
  int          disp_cnt [LANES];
  logic [AW-1:0] l_tag [LANES];
  int          l_cnt [LANES];
  bit          l_act [LANES];
  int          sim_events = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Environment: framebuffer memory, lane models and out_ready, driven just after each rising edge
  initial begin
    lane_done  = '0;
    lane_iters = '0;
    fb_rdata   = '0;
    out_ready  = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      l_act[i] = 1'b0; l_cnt[i] = 0; l_tag[i] = '0; disp_cnt[i] = 0;
    end
    for (int a = 0; a < NPIX; a++) mem[a] = '0;
    forever begin
      @(posedge clk); #1;
      if (fb_we) mem[fb_addr] = fb_wdata;
      if (fb_re) fb_rdata = mem[fb_addr];
      for (int i = 0; i < LANES; i++) begin
        lane_done[i] = 1'b0;
        if (l_act[i]) begin
          l_cnt[i]--;
          if (l_cnt[i] == 0) begin
            lane_done[i] = 1'b1;
            lane_iters[i*8 +: 8] = iters_tab[l_tag[i]];
            l_act[i] = 1'b0;
          end
        end
        if (lane_start[i]) begin
          l_tag[i] = {lane_y[i*YW +: YW], lane_x[i*XW +: XW]};
          l_act[i] = 1'b1;
          l_cnt[i] = lat_rand ? int'($urandom_range(1, 6)) : lat[i];
          disp_cnt[i]++;
        end
      end
      case (rdy_mode)
        1:       out_ready = ~out_ready;
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: framebuffer writes, simultaneous completions, byte stream scoreboard, stall stability
  initial begin
    bit         st_prev = 1'b0;
    logic [8:0] prev_b = '0;
    int         sim_state = 0;
    logic [AW-1:0] t0 = '0, t1 = '0;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        st_prev = 1'b0; sim_state = 0;
      end else begin
        if (fb_we && fb_re) check("we_re_exclusive", 1, 0);
        if (fb_we) begin
          logic [7:0] lo;
          lo = iters_tab[fb_addr] + 8'd16;
          check("fb_wdata", fb_wdata, {8'h80, lo});
          wr_cnt[fb_addr]++;
        end
        if (sim_state == 1) begin
          check("simul_first_write", {fb_we, fb_addr}, {1'b1, t0});
          sim_state = 2;
        end else if (sim_state == 2) begin
          check("simul_second_write", {fb_we, fb_addr}, {1'b1, t1});
          sim_state = 0;
        end
        if (busy && lane_done == 2'b11 && sim_state == 0) begin
          t0 = l_tag[0]; t1 = l_tag[1]; sim_state = 1; sim_events++;
        end
        if (st_prev) check("stall_stable", {out_valid, out_last, out_data}, {1'b1, prev_b});
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_byte", {out_last, out_data}, 9'h1FF);
          end else begin
            e = exp_q.pop_front();
            check("out_byte", {out_last, out_data}, e);
          end
        end
        st_prev = out_valid && !out_ready;
        prev_b  = {out_last, out_data};
      end
    end
  end

  task automatic push_frame();
    logic [7:0] lo;
    for (int a = 0; a < NPIX; a++) begin
      wr_cnt[a] = 0;
      lo = iters_tab[a] + 8'd16;
      exp_q.push_back({1'b0, lo});
      exp_q.push_back({(a == NPIX - 1), 8'h80});
    end
  endtask

  task automatic run_frame(input int rmode);
    int          cyc;
    bit          seen;
    logic [31:0] perf_ro;
    push_frame();
    rdy_mode = rmode;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("busy_after_start", busy, 1);
    cyc = 0; seen = 1'b0; perf_ro = '0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (out_valid && !seen) begin
        seen = 1'b1; perf_ro = perf_cycles;
      end
    end
    check("frame_done", done, 1);
    check("busy_clear_at_done", busy, 0);
    check("bytes_left", exp_q.size(), 0);
    for (int a = 0; a < NPIX; a++) check("write_once", wr_cnt[a], 1);
`ifdef RENDER_SCHED_PERF_EN
    check("perf_nonzero", perf_cycles != 0, 1);
    check("perf_frozen", perf_cycles, perf_ro);
`else
    check("perf_zero", perf_cycles, 0);
`endif
    exp_q.delete();
    rdy_mode = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    int wsum;
    rst = 1'b1; start = 1'b0;
    lat[0] = 3; lat[1] = 3;
    for (int a = 0; a < NPIX; a++) begin
      iters_tab[a] = 8'(a[XW-1:0] + a[AW-1:XW]);
      wr_cnt[a] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_lane_start", lane_start, 0);
    check("rst_fb", {fb_we, fb_re, out_valid, out_last}, 0);
    check("rst_perf", perf_cycles, 0);

    // Fixed latency, iters = x + y
    run_frame(0);

    // Fast lane 1, slow lane 0
    lat[0] = 9; lat[1] = 1;
    disp_cnt[0] = 0; disp_cnt[1] = 0;
    run_frame(0);
    check("lane1_share", disp_cnt[1] >= 6, 1);

    // Both lanes complete in the same cycle
    lat[0] = 4; lat[1] = 3;
    sim_events = 0;
    run_frame(0);
    check("simul_seen", sim_events > 0, 1);

    // Offset wrap and toggling out_ready
    lat[0] = 3; lat[1] = 3;
    for (int a = 0; a < NPIX; a++) iters_tab[a] = 8'(250 + a);
    run_frame(1);

    // Reset mid-render with completions arriving after reset
    lat[0] = 9; lat[1] = 9;
    for (int a = 0; a < NPIX; a++) wr_cnt[a] = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_lane_start", lane_start, 0);
    repeat (20) @(negedge clk);
    wsum = 0;
    for (int a = 0; a < NPIX; a++) wsum += wr_cnt[a];
    check("midrst_no_writes", wsum, 0);
    check("midrst_done", done, 0);
    lat[0] = 2; lat[1] = 5;
    for (int a = 0; a < NPIX; a++) iters_tab[a] = 8'(3 * a + 1);
    run_frame(0);

    // Randomized frames
    lat_rand = 1'b1;
    for (int f = 0; f < 4; f++) begin
      for (int a = 0; a < NPIX; a++) iters_tab[a] = 8'($urandom);
      run_frame(2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
